// File: rtl/sm_reg_scan_ctrl_pkg.sv
// Shared types and constants for the register-file debug scan controller.
package sm_reg_scan_ctrl_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      SETTLE  = 2'd0,
      CAPTURE = 2'd1,
      DWELL   = 2'd2
   } scan_state_t;

   // Next register in the window, wrapping from the last back to the first.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                   input int first,
                                                   input int last);
      return (addr == ADDR_W'(last)) ? ADDR_W'(first) : addr + 1'b1;
   endfunction

endpackage

// File: rtl/sm_reg_scan_ctrl_if.sv
// Debug read port plus display/control signals of the scan controller.
interface sm_reg_scan_ctrl_if;
   import sm_reg_scan_ctrl_pkg::*;

   logic              autoMode;
   logic              stepKey;
   logic              hold;
   logic [ADDR_W-1:0] regAddr;
   logic [DATA_W-1:0] regData;
   logic [DATA_W-1:0] dispData;
   logic [ADDR_W-1:0] dispAddr;
   logic              capValid;

   modport master (
      input  autoMode, stepKey, hold, regData,
      output regAddr, dispData, dispAddr, capValid
   );

   modport slave (
      output autoMode, stepKey, hold, regData,
      input  regAddr, dispData, dispAddr, capValid
   );

endinterface

// File: rtl/sm_reg_scan_ctrl_sync_edge.sv
// Two-flop synchronizer on an asynchronous level followed by a rising-edge pulse.
module sm_sync_edge (
   input  logic clkIn,
   input  logic rst,
   input  logic level,
   output logic rise
);

   // [0],[1] form the synchronizer; [2] is the previous synchronized level.
   logic [2:0] sync_q;

   // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge clkIn) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[1:0], level};
   end

   assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/sm_reg_scan_ctrl.sv
// Register-window scan scheduler for the core's debug read port: settle, capture, dwell, advance.
module sm_reg_scan_ctrl
   import sm_reg_scan_ctrl_pkg::*;
#(
   parameter int REG_FIRST  = 1,
   parameter int REG_LAST   = 7,
   parameter int SETTLE_CYC = 4,
   parameter int DWELL_W    = 24,
   parameter int DWELL_CYC  = 12500000
) (
   input  logic               clkIn,
   input  logic               rst,
   sm_reg_scan_ctrl_if.master bus
);

   localparam int                  SETTLE_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
   localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(DWELL_CYC - 1);

   scan_state_t       state, state_next;
   logic [SETTLE_W-1:0] settle_cnt, settle_cnt_next;
   logic [DWELL_W-1:0]  dwell_cnt, dwell_cnt_next;
   logic [ADDR_W-1:0]   addr_q, addr_next;
   logic [DATA_W-1:0]   disp_data;
   logic [ADDR_W-1:0]   disp_addr;
   logic                cap_valid;
   logic                capture;
   logic                advance;
   logic                step_pulse;

   sm_sync_edge u_step (
      .clkIn (clkIn),
      .rst   (rst),
      .level (bus.stepKey),
      .rise  (step_pulse)
   );

   always_ff @(posedge clkIn) begin
      if (rst) state <= SETTLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_next      = state;
      settle_cnt_next = settle_cnt;
      dwell_cnt_next  = dwell_cnt;
      addr_next       = addr_q;
      capture         = 1'b0;
      advance         = 1'b0;

      unique case (state)
         SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_next      = CAPTURE;
               settle_cnt_next = '0;
            end else begin
               settle_cnt_next = settle_cnt + 1'b1;
            end
         end
         CAPTURE: begin
            capture        = 1'b1;
            state_next     = DWELL;
            dwell_cnt_next = '0;
         end
         DWELL: begin
            // A step pre-empts the timed dwell; hold blocks steps but still refreshes.
            if (step_pulse && !bus.hold) begin
               advance = 1'b1;
            end else if (bus.autoMode) begin
               if (dwell_cnt == DWELL_LAST) begin
                  state_next     = SETTLE;
                  dwell_cnt_next = '0;
                  advance        = !bus.hold;
               end else begin
                  dwell_cnt_next = dwell_cnt + 1'b1;
               end
            end
         end
         default: state_next = SETTLE;
      endcase

      if (advance) begin
         state_next     = SETTLE;
         dwell_cnt_next = '0;
         addr_next      = next_addr(addr_q, REG_FIRST, REG_LAST);
      end
   end

   always_ff @(posedge clkIn) begin
      if (rst) begin
         settle_cnt <= '0;
         dwell_cnt  <= '0;
         addr_q     <= ADDR_W'(REG_FIRST);
         disp_data  <= '0;
         disp_addr  <= '0;
         cap_valid  <= 1'b0;
      end else begin
         settle_cnt <= settle_cnt_next;
         dwell_cnt  <= dwell_cnt_next;
         addr_q     <= addr_next;
         cap_valid  <= capture;
         if (capture) begin
            disp_data <= bus.regData;
            disp_addr <= addr_q;
         end
      end
   end

   assign bus.regAddr  = addr_q;
   assign bus.dispData = disp_data;
   assign bus.dispAddr = disp_addr;
   assign bus.capValid = cap_valid;

endmodule

// File: tb/tb_sm_reg_scan_ctrl.sv
// Scoreboard bench for sm_reg_scan_ctrl: directed scenarios then randomized stimulus against a procedural model.
module tb_sm_reg_scan_ctrl;
   import sm_reg_scan_ctrl_pkg::*;

   localparam int REG_FIRST  = 1;
   localparam int REG_LAST   = 3;
   localparam int SETTLE_CYC = 2;
   localparam int DWELL_W    = 8;
   localparam int DWELL_CYC  = 4;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int                at;
   } cap_t;

   logic clkIn = 1'b0;
   logic rst   = 1'b1;
   logic [DATA_W-1:0] reg_file [32];

   sm_reg_scan_ctrl_if bus();

   assign bus.regData = reg_file[bus.regAddr];

   sm_reg_scan_ctrl #(
      .REG_FIRST  (REG_FIRST),
      .REG_LAST   (REG_LAST),
      .SETTLE_CYC (SETTLE_CYC),
      .DWELL_W    (DWELL_W),
      .DWELL_CYC  (DWELL_CYC)
   ) dut (
      .clkIn (clkIn),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clkIn = ~clkIn;

   int edge_cnt = 0;
   always @(posedge clkIn) edge_cnt <= edge_cnt + 1;

   int checks   = 0;
   int failures = 0;
   int cap_seen = 0;
   cap_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edge_cnt);
      end
   endtask

   // ---------------- reference model ----------------
   logic [ADDR_W-1:0] m_addr      = '0;
   logic [ADDR_W-1:0] m_disp_addr = '0;
   logic [DATA_W-1:0] m_disp_data = '0;
   bit m_rst, m_step, m_auto, m_hold;
   bit key_hist[$] = '{1'b0, 1'b0, 1'b0};

   function automatic logic [ADDR_W-1:0] wrap_next(input logic [ADDR_W-1:0] a);
      if (int'(a) >= REG_LAST) return ADDR_W'(REG_FIRST);
      return ADDR_W'(int'(a) + 1);
   endfunction

   // One clock edge as seen by the model; a step counts when the key rose two edges ago.
   task automatic tick();
      @(posedge clkIn);
      m_rst  = rst;
      m_auto = bus.autoMode;
      m_hold = bus.hold;
      if (rst) begin
         m_addr      = ADDR_W'(REG_FIRST);
         m_disp_addr = '0;
         m_disp_data = '0;
         m_step      = 1'b0;
         key_hist    = '{1'b0, 1'b0, 1'b0};
      end else begin
         m_step = key_hist[key_hist.size()-2] && !key_hist[key_hist.size()-3];
         key_hist.push_back(bus.stepKey);
         if (key_hist.size() > 4) void'(key_hist.pop_front());
      end
   endtask

   // Visits registers until a reset edge is seen, then returns so the caller restarts.
   task automatic visit_loop();
      int dcount;
      forever begin
         repeat (SETTLE_CYC) begin
            tick();
            if (m_rst) return;
         end
         tick();
         if (m_rst) return;
         m_disp_addr = m_addr;
         m_disp_data = reg_file[m_addr];
         exp_q.push_back(cap_t'{m_addr, m_disp_data, edge_cnt + 1});
         dcount = 0;
         forever begin
            tick();
            if (m_rst) return;
            if (m_step && !m_hold) begin
               m_addr = wrap_next(m_addr);
               break;
            end
            if (m_auto) begin
               if (dcount == DWELL_CYC - 1) begin
                  if (!m_hold) m_addr = wrap_next(m_addr);
                  break;
               end
               dcount++;
            end
         end
      end
   endtask

   initial forever visit_loop();

   // ---------------- monitor ----------------
   initial begin
      cap_t e;
      forever begin
         @(negedge clkIn);
         check("regAddr", 64'(bus.regAddr), 64'(m_addr));
         check("dispAddr", 64'(bus.dispAddr), 64'(m_disp_addr));
         check("dispData", 64'(bus.dispData), 64'(m_disp_data));
         if (exp_q.size() > 0 && exp_q[0].at <= edge_cnt) begin
            e = exp_q.pop_front();
            check("capValid_pulse", 64'(bus.capValid), 64'(1));
            check("cap_edge", 64'(edge_cnt), 64'(e.at));
            check("cap_addr", 64'(bus.dispAddr), 64'(e.addr));
            check("cap_data", 64'(bus.dispData), 64'(e.data));
         end else begin
            check("capValid_idle", 64'(bus.capValid), 64'(0));
         end
         if (bus.capValid === 1'b1) cap_seen++;
      end
   end

   // ---------------- stimulus ----------------
   int base;

   task automatic goto(input int e);
      while (edge_cnt < base + e) @(negedge clkIn);
   endtask

   // Reset edge becomes relative edge 0 of the following scenario.
   task automatic do_reset(input bit auto_v, input bit hold_v);
      @(negedge clkIn);
      rst          = 1'b1;
      bus.autoMode = auto_v;
      bus.hold     = hold_v;
      bus.stepKey  = 1'b0;
      @(negedge clkIn);
      rst  = 1'b0;
      base = edge_cnt;
   endtask

   initial begin
      int c0;
      bus.autoMode = 1'b1;
      bus.hold     = 1'b0;
      bus.stepKey  = 1'b0;
      for (int i = 0; i < 32; i++) reg_file[i] = 32'h10 + i;

      // Timed scan with wrap 3 -> 1.
      do_reset(1'b1, 1'b0);
      #1;
      check("rst_capValid", 64'(bus.capValid), 64'(0));
      check("rst_regAddr", 64'(bus.regAddr), 64'(REG_FIRST));
      c0 = cap_seen;
      goto(24); #1;
      check("s1_capture_count", 64'(cap_seen - c0), 64'(4));
      check("s1_wrap_addr", 64'(bus.dispAddr), 64'(1));
      check("s1_wrap_data", 64'(bus.dispData), 64'(32'h11));

      // Manual step: one 3-cycle press gives one advance.
      do_reset(1'b0, 1'b0);
      c0 = cap_seen;
      goto(6);  bus.stepKey = 1'b1;
      goto(9);  bus.stepKey = 1'b0;
      #1;
      check("s2_advanced", 64'(bus.regAddr), 64'(2));
      goto(40); #1;
      check("s2_capture_count", 64'(cap_seen - c0), 64'(2));
      check("s2_addr_stays", 64'(bus.regAddr), 64'(2));

      // Hold refresh picks up changed data.
      do_reset(1'b1, 1'b1);
      reg_file[1] = 32'h11;
      goto(4);  reg_file[1] = 32'hAB;
      goto(10); #1;
      check("s3_refresh_data", 64'(bus.dispData), 64'(32'hAB));
      check("s3_addr_held", 64'(bus.regAddr), 64'(1));
      reg_file[1] = 32'h11;

      // Step pre-empts dwell; a step landing in SETTLE is dropped.
      do_reset(1'b1, 1'b0);
      c0 = cap_seen;
      goto(1);  bus.stepKey = 1'b1;
      goto(3);  bus.stepKey = 1'b0;
      goto(7);  #1;
      check("s4_early_capture", 64'(cap_seen - c0), 64'(2));
      check("s4_early_addr", 64'(bus.dispAddr), 64'(2));
      goto(9);  bus.stepKey = 1'b1;
      goto(10); bus.stepKey = 1'b0;
      goto(13); #1;
      check("s4_dropped_step", 64'(cap_seen - c0), 64'(2));
      goto(14); #1;
      check("s4_normal_capture", 64'(cap_seen - c0), 64'(3));
      check("s4_normal_addr", 64'(bus.dispAddr), 64'(3));

      // Reset during CAPTURE of register 2.
      do_reset(1'b1, 1'b0);
      goto(9);  rst = 1'b1;
      goto(10); rst = 1'b0; #1;
      check("s5_dispData", 64'(bus.dispData), 64'(0));
      check("s5_dispAddr", 64'(bus.dispAddr), 64'(0));
      check("s5_capValid", 64'(bus.capValid), 64'(0));
      check("s5_regAddr", 64'(bus.regAddr), 64'(1));
      base = edge_cnt;
      goto(3); #1;
      check("s5_restart_addr", 64'(bus.dispAddr), 64'(1));

      // Pause auto dwell at count 2 for 20 cycles.
      do_reset(1'b1, 1'b0);
      goto(5);  bus.autoMode = 1'b0;
      goto(25); bus.autoMode = 1'b1;
      goto(26); #1;
      check("s6_not_yet", 64'(bus.regAddr), 64'(1));
      goto(27); #1;
      check("s6_advance", 64'(bus.regAddr), 64'(2));

      // Randomized stimulus against the model.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clkIn);
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) bus.autoMode = ~bus.autoMode;
         if ($urandom_range(0, 49) == 0) bus.hold = ~bus.hold;
         if ($urandom_range(0, 5) == 0) bus.stepKey = ~bus.stepKey;
         if ($urandom_range(0, 3) == 0) reg_file[$urandom_range(0, 31)] = $urandom;
      end
      @(negedge clkIn);
      rst = 1'b0;
      repeat (3) @(negedge clkIn);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
